// File: rtl/clock_divide_multi.sv
// -----------------------------------------------------------------------------
// clock_divide_multi
//
// Multi-channel programmable clock divider. Each of CHANNELS channels counts
// clock_in cycles from 0 to div-1 and produces a registered divided level
// (clk_out, high while cnt < high) and a one-cycle period-start pulse (tick).
// A channel's divisor, high time and enable are reprogrammed at run time
// through a valid/ready config port. Writes to a running channel are held in
// a shadow register and applied at the next period boundary (wrap or sync_all),
// so the outputs never show a runt pulse. Writes to a disabled channel, or
// writes that land exactly on a boundary, take effect immediately.
//
// Ports:
//   clock_in   in   1         sole clock, rising edge
//   reset_n    in   1         asynchronous active-low reset
//   cfg_valid  in   1         config request
//   cfg_ready  out  1         target channel can accept (no shadow pending)
//   cfg_chan   in   CH_W      target channel
//   cfg_div    in   WIDTH     period in clock_in cycles (values < 2 become 2)
//   cfg_high   in   WIDTH     high cycles per period
//   cfg_en     in   1         channel enable
//   sync_all   in   1         one-cycle pulse, restarts every enabled channel
//   clk_out    out  CHANNELS  divided clock levels (registered)
//   tick       out  CHANNELS  period-start pulses (registered)
//   pending    out  CHANNELS  shadow config waiting for a boundary
// -----------------------------------------------------------------------------
module clock_divide_multi #(
    parameter int                CH_W        = 2,
    parameter int                WIDTH       = 28,
    parameter logic [WIDTH-1:0]  DEFAULT_DIV = WIDTH'(14000000),
    localparam int               CHANNELS    = 2**CH_W
) (
    input  logic                clock_in,
    input  logic                reset_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [WIDTH-1:0]    cfg_div,
    input  logic [WIDTH-1:0]    cfg_high,
    input  logic                cfg_en,
    input  logic                sync_all,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    localparam logic [WIDTH-1:0] DEFAULT_HIGH = DEFAULT_DIV >> 1;
    localparam logic [WIDTH-1:0] DIV_MIN      = WIDTH'(2);

    typedef struct packed {
        logic [WIDTH-1:0] div;
        logic [WIDTH-1:0] high;
        logic             en;
    } chan_cfg_t;

    localparam chan_cfg_t CFG_DEFAULT = '{div: DEFAULT_DIV, high: DEFAULT_HIGH, en: 1'b1};

    logic [WIDTH-1:0]    cnt    [CHANNELS];
    chan_cfg_t           active [CHANNELS];
    chan_cfg_t           shadow [CHANNELS];

    chan_cfg_t           cfg_new;
    logic                accept;
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] boundary;

    // Ready depends only on the target channel's pending flag, never on
    // cfg_valid, so the requester cannot form a combinational loop.
    assign cfg_ready = ~pending[cfg_chan];
    assign accept    = cfg_valid & cfg_ready;

    // NOTE: every signal written in always_comb gets a value before any
    // condition, otherwise an unassigned path infers a latch.
    always_comb begin
        cfg_new      = CFG_DEFAULT;
        cfg_new.div  = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
        cfg_new.high = cfg_high;
        cfg_new.en   = cfg_en;
    end

    // A boundary is the last count of a period or a sync_all pulse; only an
    // enabled channel has one (a disabled channel just sits at cnt=0).
    always_comb begin
        hit      = '0;
        boundary = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hit[i]      = accept && (cfg_chan == CH_W'(i));
            boundary[i] = active[i].en &&
                          (sync_all || (cnt[i] == active[i].div - 1'b1));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the per-channel arrays are plain flops, not RAM, so they
            // are all reset; this is what discards shadow values on reset.
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i]    <= '0;
                active[i] <= CFG_DEFAULT;
                shadow[i] <= CFG_DEFAULT;
            end
            pending <= '0;
            clk_out <= '0;
            tick    <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                // Outputs are decoded from the pre-edge count, so they lag
                // cnt by one cycle.
                clk_out[i] <= active[i].en && (cnt[i] < active[i].high);
                tick[i]    <= active[i].en && (cnt[i] == '0);

                if (hit[i] && (!active[i].en || boundary[i])) begin
                    // Disabled channel or boundary right now: apply directly.
                    active[i] <= cfg_new;
                    cnt[i]    <= '0;
                end else if (hit[i]) begin
                    // Mid-period on a running channel: defer to the boundary.
                    shadow[i]  <= cfg_new;
                    pending[i] <= 1'b1;
                    cnt[i]     <= cnt[i] + 1'b1;
                end else if (boundary[i]) begin
                    cnt[i] <= '0;
                    if (pending[i]) begin
                        active[i]  <= shadow[i];
                        pending[i] <= 1'b0;
                    end
                end else if (active[i].en) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_divide_multi.sv
// -----------------------------------------------------------------------------
// tb_clock_divide_multi
//
// Self-checking bench for clock_divide_multi (CH_W=2, DEFAULT_DIV=10). A
// cycle model of the divider predicts clk_out/tick/pending for every edge;
// the prediction is queued when the inputs are driven and compared after the
// edge. Directed scenarios add explicit period/count checks on top.
// -----------------------------------------------------------------------------
module tb_clock_divide_multi;

    localparam int CH_W  = 2;
    localparam int WIDTH = 28;
    localparam int NCH   = 4;

    logic             clock_in;
    logic             reset_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_chan;
    logic [WIDTH-1:0] cfg_div;
    logic [WIDTH-1:0] cfg_high;
    logic             cfg_en;
    logic             sync_all;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   pending;

    clock_divide_multi #(
        .CH_W        (CH_W),
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (28'd10)
    ) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .cfg_en    (cfg_en),
        .sync_all  (sync_all),
        .clk_out   (clk_out),
        .tick      (tick),
        .pending   (pending)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [NCH-1:0] clk;
        logic [NCH-1:0] tck;
        logic [NCH-1:0] pnd;
    } exp_t;

    exp_t             sb_q[$];

    logic [WIDTH-1:0] m_cnt  [NCH];
    logic [WIDTH-1:0] m_div  [NCH];
    logic [WIDTH-1:0] m_high [NCH];
    logic [WIDTH-1:0] s_div  [NCH];
    logic [WIDTH-1:0] s_high [NCH];
    logic [NCH-1:0]   m_en, s_en, m_pend, m_clk, m_tick;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i]  = '0;
            m_div[i]  = 28'd10;
            m_high[i] = 28'd5;
            s_div[i]  = 28'd10;
            s_high[i] = 28'd5;
        end
        m_en   = '1;
        s_en   = '1;
        m_pend = '0;
        m_clk  = '0;
        m_tick = '0;
    endtask

    task automatic model_edge();
        logic             acc;
        logic [WIDTH-1:0] ndiv;
        logic             last, bnd;
        acc  = cfg_valid && !m_pend[cfg_chan];
        ndiv = (cfg_div < 28'd2) ? 28'd2 : cfg_div;
        for (int i = 0; i < NCH; i++) begin
            m_clk[i]  = m_en[i] && (m_cnt[i] < m_high[i]);
            m_tick[i] = m_en[i] && (m_cnt[i] == 0);
            last = (m_cnt[i] + 28'd1 == m_div[i]);
            bnd  = m_en[i] && (last || sync_all);
            if (acc && (int'(cfg_chan) == i)) begin
                if (!m_en[i] || bnd) begin
                    m_div[i] = ndiv; m_high[i] = cfg_high; m_en[i] = cfg_en;
                    m_cnt[i] = '0;
                end else begin
                    s_div[i] = ndiv; s_high[i] = cfg_high; s_en[i] = cfg_en;
                    m_pend[i] = 1'b1;
                    m_cnt[i]  = m_cnt[i] + 28'd1;
                end
            end else if (bnd) begin
                m_cnt[i] = '0;
                if (m_pend[i]) begin
                    m_div[i] = s_div[i]; m_high[i] = s_high[i]; m_en[i] = s_en[i];
                    m_pend[i] = 1'b0;
                end
            end else if (m_en[i]) begin
                m_cnt[i] = m_cnt[i] + 28'd1;
            end else begin
                m_cnt[i] = '0;
            end
        end
    endtask

    // One clock: check ready, predict, clock, compare against prediction.
    task automatic step();
        exp_t e;
        #1;
        check("cfg_ready", {31'b0, cfg_ready}, {31'b0, ~m_pend[cfg_chan]});
        model_edge();
        sb_q.push_back('{clk: m_clk, tck: m_tick, pnd: m_pend});
        @(posedge clock_in);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("clk_out", {28'b0, clk_out}, {28'b0, e.clk});
            check("tick",    {28'b0, tick},    {28'b0, e.tck});
            check("pending", {28'b0, pending}, {28'b0, e.pnd});
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic cfg_write(input int ch, input int dv, input int hi, input logic en);
        cfg_valid = 1'b1;
        cfg_chan  = CH_W'(ch);
        cfg_div   = WIDTH'(dv);
        cfg_high  = WIDTH'(hi);
        cfg_en    = en;
        step();
        cfg_valid = 1'b0;
    endtask

    // Run n cycles and count highs/ticks seen on one channel.
    task automatic measure(input int ch, input int n, output int highs, output int ticks);
        highs = 0;
        ticks = 0;
        for (int k = 0; k < n; k++) begin
            step();
            highs += int'(clk_out[ch]);
            ticks += int'(tick[ch]);
        end
    endtask

    initial begin
        int hs, ts;
        reset_n   = 1'b0;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_div   = '0;
        cfg_high  = '0;
        cfg_en    = 1'b0;
        sync_all  = 1'b0;
        model_reset();

        #23;
        check("rst_outputs", {20'b0, clk_out, tick, pending}, 32'd0);
        check("rst_ready",   {31'b0, cfg_ready}, 32'd1);

        @(posedge clock_in);
        #1 reset_n = 1'b1;

        // Defaults: first tick one cycle after release, 5 high / 5 low.
        step();
        check("first_tick",  {28'b0, tick},    32'hf);
        check("first_high",  {28'b0, clk_out}, 32'hf);
        measure(0, 19, hs, ts);
        check("def_highs", hs, 9);
        check("def_ticks", ts, 1);
        steps(3);   // 23 edges: every cnt = 3

        // Channel 1 deferred write at cnt=3, stalled while pending.
        cfg_write(1, 4, 1, 1'b1);
        check("ch1_pending", {28'b0, pending}, 32'h2);
        cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_div = 28'd7; cfg_high = 28'd3; cfg_en = 1'b1;
        #1;
        check("ch1_stall_ready", {31'b0, cfg_ready}, 32'd0);
        steps(2);
        cfg_valid = 1'b0;
        steps(4);   // wrap at cnt=9
        check("ch1_applied", {28'b0, pending}, 32'h0);
        measure(1, 8, hs, ts);
        check("ch1_highs", hs, 2);
        check("ch1_ticks", ts, 2);

        // Channel 2: disable (takes effect at boundary), then immediate enable.
        cfg_write(2, 10, 5, 1'b0);
        steps(12);
        measure(2, 4, hs, ts);
        check("ch2_off", hs + ts, 0);
        cfg_write(2, 3, 2, 1'b1);
        measure(2, 9, hs, ts);
        check("ch2_highs", hs, 6);
        check("ch2_ticks", ts, 3);

        // Channel 3: divisor clamp, then high >= div.
        cfg_write(3, 0, 1, 1'b1);
        steps(12);
        measure(3, 6, hs, ts);
        check("ch3_clamp_highs", hs, 3);
        check("ch3_clamp_ticks", ts, 3);
        cfg_write(3, 5, 7, 1'b1);
        steps(12);
        measure(3, 10, hs, ts);
        check("ch3_const_highs", hs, 10);
        check("ch3_const_ticks", ts, 2);

        // sync_all: all ticks coincide one cycle after the pulse edge.
        sync_all = 1'b1;
        step();
        sync_all = 1'b0;
        step();
        check("sync_ticks", {28'b0, tick}, 32'hf);

        // Deferred write on channel 0, then asynchronous reset mid-period.
        if (m_cnt[0] + 28'd1 == m_div[0]) step();
        cfg_write(0, 6, 2, 1'b1);
        check("ch0_pending", {31'b0, pending[0]}, 32'd1);
        steps(2);
        reset_n = 1'b0;
        #2;
        check("async_rst", {20'b0, clk_out, tick, pending}, 32'd0);
        model_reset();
        @(posedge clock_in);
        #1 reset_n = 1'b1;
        step();
        check("rst_first_tick", {31'b0, tick[0]}, 32'd1);
        measure(0, 20, hs, ts);
        check("rst_def_highs", hs, 10);
        check("rst_def_ticks", ts, 2);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            cfg_valid = ($urandom_range(0, 9) < 3);
            cfg_chan  = CH_W'($urandom_range(0, 3));
            cfg_div   = WIDTH'($urandom_range(0, 7));
            cfg_high  = WIDTH'($urandom_range(0, 8));
            cfg_en    = ($urandom_range(0, 9) < 8);
            sync_all  = ($urandom_range(0, 19) == 0);
            step();
        end
        cfg_valid = 1'b0;
        sync_all  = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
